// File: rtl/i2c_cmd_queue.sv
// i2c_cmd_queue: buffers I2C commands, issues them one at a time to an I2C
// controller, and queues the completed results (data, ack error, timeout).
module i2c_cmd_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_op,
    output logic       rsp_err,
    output logic       rsp_timeout,
    output logic       i2c_newd,
    output logic       i2c_op,
    output logic [6:0] i2c_addr,
    output logic [7:0] i2c_din,
    input  logic [7:0] i2c_dout,
    input  logic       i2c_busy,
    input  logic       i2c_ack_err,
    input  logic       i2c_done,
    output logic [4:0] cmd_count,
    output logic       idle
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [4:0]    FULL_CNT = 5'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    // Command FIFO: entry {op, addr, data}
    logic [15:0]   cmd_mem_q [DEPTH];
    logic [AW-1:0] cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
    logic [4:0]    cmd_cnt_q, cmd_cnt_d;
    logic          cmd_push, cmd_pop;
    logic [15:0]   cmd_head;

    // Response FIFO: entry {timeout, err, op, data}
    logic [10:0]   rsp_mem_q [DEPTH];
    logic [AW-1:0] rsp_wptr_q, rsp_wptr_d, rsp_rptr_q, rsp_rptr_d;
    logic [4:0]    rsp_cnt_q, rsp_cnt_d;
    logic          rsp_push, rsp_pop;
    logic [10:0]   rsp_head, rsp_entry;

    // Transaction state
    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          newd_q, newd_d;
    logic          op_q, op_d;
    logic [6:0]    addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic [10:0]   cap_q, cap_d;

    assign cmd_ready = (cmd_cnt_q != FULL_CNT);
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_head  = cmd_mem_q[cmd_rptr_q];
    assign cmd_count = cmd_cnt_q;

    assign rsp_valid = (rsp_cnt_q != 5'd0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_head  = rsp_mem_q[rsp_rptr_q];
    // Storage is not reset, so an empty FIFO presents zeros instead of stale data.
    assign rsp_entry = rsp_valid ? rsp_head : 11'd0;
    assign {rsp_timeout, rsp_err, rsp_op, rsp_data} = rsp_entry;

    assign i2c_newd = newd_q;
    assign i2c_op   = op_q;
    assign i2c_addr = addr_q;
    assign i2c_din  = din_q;
    assign idle     = (state_q == S_IDLE) && (cmd_cnt_q == 5'd0) && (rsp_cnt_q == 5'd0);

    // Next pointers and occupancy for both FIFOs; push+pop together keeps the count.
    always_comb begin
        cmd_wptr_d = cmd_push ? cmd_wptr_q + AW'(1) : cmd_wptr_q;
        cmd_rptr_d = cmd_pop  ? cmd_rptr_q + AW'(1) : cmd_rptr_q;
        cmd_cnt_d  = cmd_cnt_q;
        if (cmd_push && !cmd_pop) cmd_cnt_d = cmd_cnt_q + 5'd1;
        else if (!cmd_push && cmd_pop) cmd_cnt_d = cmd_cnt_q - 5'd1;

        rsp_wptr_d = rsp_push ? rsp_wptr_q + AW'(1) : rsp_wptr_q;
        rsp_rptr_d = rsp_pop  ? rsp_rptr_q + AW'(1) : rsp_rptr_q;
        rsp_cnt_d  = rsp_cnt_q;
        if (rsp_push && !rsp_pop) rsp_cnt_d = rsp_cnt_q + 5'd1;
        else if (!rsp_push && rsp_pop) rsp_cnt_d = rsp_cnt_q - 5'd1;
    end

    // FIFO storage writes (data path, no reset)
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem_q[cmd_wptr_q] <= {cmd_op, cmd_addr, cmd_data};
        if (rsp_push) rsp_mem_q[rsp_wptr_q] <= cap_q;
    end

    // Transaction FSM: next state, controller handshake and result capture
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        newd_d   = 1'b0;
        op_d     = op_q;
        addr_d   = addr_q;
        din_d    = din_q;
        cap_d    = cap_q;
        cmd_pop  = 1'b0;
        rsp_push = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Only start when the result is guaranteed a slot in the response FIFO.
                if ((cmd_cnt_q != 5'd0) && (rsp_cnt_q != FULL_CNT)) begin
                    cmd_pop               = 1'b1;
                    {op_d, addr_d, din_d} = cmd_head;
                    state_d               = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!i2c_busy) begin
                    newd_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A done in the last allowed cycle still counts as a completion.
                if (i2c_done) begin
                    cap_d   = {1'b0, i2c_ack_err, op_q, (op_q ? i2c_dout : 8'h00)};
                    state_d = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    cap_d   = {1'b1, 1'b1, op_q, 8'h00};
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RESP: begin
                rsp_push = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tmo_q      <= '0;
            newd_q     <= 1'b0;
            op_q       <= 1'b0;
            addr_q     <= 7'd0;
            din_q      <= 8'd0;
            cmd_wptr_q <= '0;
            cmd_rptr_q <= '0;
            cmd_cnt_q  <= 5'd0;
            rsp_wptr_q <= '0;
            rsp_rptr_q <= '0;
            rsp_cnt_q  <= 5'd0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            newd_q     <= newd_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            cmd_wptr_q <= cmd_wptr_d;
            cmd_rptr_q <= cmd_rptr_d;
            cmd_cnt_q  <= cmd_cnt_d;
            rsp_wptr_q <= rsp_wptr_d;
            rsp_rptr_q <= rsp_rptr_d;
            rsp_cnt_q  <= rsp_cnt_d;
        end
    end

    // Captured result, only meaningful once RESP pushes it
    always_ff @(posedge clk) begin
        cap_q <= cap_d;
    end

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Testbench for i2c_cmd_queue: directed vector table, multi-cycle corner
// sequences and a randomized run against a queue-based reference model.
module tb_i2c_cmd_queue;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic       clk, rst;
    logic       cmd_valid, cmd_ready, cmd_op;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_op, rsp_err, rsp_timeout;
    logic       i2c_newd, i2c_op;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_din, i2c_dout;
    logic       i2c_busy, i2c_ack_err, i2c_done;
    logic [4:0] cmd_count;
    logic       idle;

    i2c_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_op(rsp_op), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .i2c_newd(i2c_newd), .i2c_op(i2c_op), .i2c_addr(i2c_addr),
        .i2c_din(i2c_din), .i2c_dout(i2c_dout), .i2c_busy(i2c_busy),
        .i2c_ack_err(i2c_ack_err), .i2c_done(i2c_done),
        .cmd_count(cmd_count), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int newd_cnt = 0;
    int pushed_cnt = 0;

    // Reference model: commands accepted but not yet issued, and responses
    // expected but not yet consumed, both in order.
    bit [15:0] exp_cmd_q[$];
    bit [10:0] exp_rsp_q[$];
    bit        auto_ctl = 1'b0;
    bit        in_flight = 1'b0;
    int        dly = 0;
    int        max_delay = 8;
    bit        pend_ack;
    bit [7:0]  pend_dout;
    bit [10:0] pend_rsp;

    typedef struct {
        logic       op;
        logic [6:0] addr;
        logic [7:0] data;
        logic       ack;
        logic [7:0] dout;
        int         delay;
        logic [7:0] e_data;
        logic       e_err;
        logic       e_to;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual=event required=none", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (i2c_newd) newd_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = 7'd0; cmd_data = 8'd0;
        rsp_ready = 1'b0;
        i2c_busy = 1'b0; i2c_done = 1'b0; i2c_ack_err = 1'b0; i2c_dout = 8'd0;
        step();
        step();
        rst = 1'b0;
        exp_cmd_q.delete();
        exp_rsp_q.delete();
        in_flight = 1'b0;
        newd_cnt = 0;
        pushed_cnt = 0;
    endtask

    // One cycle of model-driven traffic: controller model, response consumer,
    // command producer. Called at the sampling point just after a clock edge.
    task automatic tick(input bit push, input bit [15:0] cmd, input bit pop);
        bit [15:0] e;
        if (auto_ctl && i2c_newd) begin
            if (in_flight) fail_evt("newd_overlap");
            e = 16'd0;
            if (exp_cmd_q.size() == 0) fail_evt("newd_unexpected");
            else begin
                e = exp_cmd_q.pop_front();
                check("issue_cmd", 32'({i2c_op, i2c_addr, i2c_din}), 32'(e));
            end
            in_flight = 1'b1;
            dly = int'($urandom_range(0, max_delay));
            pend_ack = 1'($urandom_range(0, 1));
            pend_dout = 8'($urandom);
            pend_rsp = {1'b0, pend_ack, e[15], (e[15] ? pend_dout : 8'h00)};
        end
        i2c_done = 1'b0;
        i2c_ack_err = 1'($urandom_range(0, 1));
        i2c_dout = 8'($urandom);
        if (auto_ctl && in_flight) begin
            if (dly == 0) begin
                i2c_done = 1'b1;
                i2c_ack_err = pend_ack;
                i2c_dout = pend_dout;
                exp_rsp_q.push_back(pend_rsp);
                in_flight = 1'b0;
            end else begin
                dly--;
            end
        end
        rsp_ready = pop;
        if (pop && rsp_valid) begin
            if (exp_rsp_q.size() == 0) fail_evt("rsp_unexpected");
            else check("rsp_entry", 32'({rsp_timeout, rsp_err, rsp_op, rsp_data}),
                       32'(exp_rsp_q.pop_front()));
        end
        cmd_valid = push;
        {cmd_op, cmd_addr, cmd_data} = cmd;
        if (push && cmd_ready) begin
            exp_cmd_q.push_back(cmd);
            pushed_cnt++;
        end
        step();
    endtask

    task automatic drain(input int limit);
        i2c_busy = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (exp_cmd_q.size() == 0 && exp_rsp_q.size() == 0 && !in_flight && idle) break;
            tick(1'b0, 16'd0, 1'b1);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        i2c_done = 1'b0;
        check("drain_cmd_left", 32'(exp_cmd_q.size()), 32'd0);
        check("drain_rsp_left", 32'(exp_rsp_q.size()), 32'd0);
        check("drain_idle", 32'(idle), 32'd1);
    endtask

    task automatic push_one(input bit [15:0] cmd);
        cmd_valid = 1'b1;
        {cmd_op, cmd_addr, cmd_data} = cmd;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_newd(input string name);
        for (int i = 0; i < 10 && !i2c_newd; i++) step();
        check(name, 32'(i2c_newd), 32'd1);
    endtask

    task automatic wait_rsp(input string name);
        for (int i = 0; i < 8 && !rsp_valid; i++) step();
        check(name, 32'(rsp_valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int n0;
        n0 = newd_cnt;
        push_one({v.op, v.addr, v.data});
        wait_newd("vec_newd_seen");
        check("vec_issue", 32'({i2c_op, i2c_addr, i2c_din}), 32'({v.op, v.addr, v.data}));
        repeat (v.delay) step();
        i2c_done = 1'b1; i2c_ack_err = v.ack; i2c_dout = v.dout;
        step();
        i2c_done = 1'b0; i2c_ack_err = 1'b0;
        wait_rsp("vec_rsp_seen");
        check("vec_rsp", 32'({rsp_timeout, rsp_err, rsp_op, rsp_data}),
              32'({v.e_to, v.e_err, v.op, v.e_data}));
        check("vec_newd_pulses", 32'(newd_cnt - n0), 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("vec_idle_after", 32'(idle), 32'd1);
    endtask

    initial begin
        int n, n0;
        vecs[0] = '{op:1'b0, addr:7'h50, data:8'hA5, ack:1'b0, dout:8'h77, delay:20,
                    e_data:8'h00, e_err:1'b0, e_to:1'b0};
        vecs[1] = '{op:1'b1, addr:7'h21, data:8'h00, ack:1'b0, dout:8'h3C, delay:5,
                    e_data:8'h3C, e_err:1'b0, e_to:1'b0};
        vecs[2] = '{op:1'b1, addr:7'h21, data:8'h00, ack:1'b1, dout:8'h3C, delay:5,
                    e_data:8'h3C, e_err:1'b1, e_to:1'b0};
        vecs[3] = '{op:1'b0, addr:7'h7F, data:8'hFF, ack:1'b1, dout:8'h12, delay:0,
                    e_data:8'h00, e_err:1'b1, e_to:1'b0};
        vecs[4] = '{op:1'b1, addr:7'h00, data:8'h5A, ack:1'b0, dout:8'hFF, delay:0,
                    e_data:8'hFF, e_err:1'b0, e_to:1'b0};
        vecs[5] = '{op:1'b1, addr:7'h45, data:8'h00, ack:1'b0, dout:8'h5A, delay:TIMEOUT-1,
                    e_data:8'h5A, e_err:1'b0, e_to:1'b0};

        // Reset state
        do_reset();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_count", 32'(cmd_count), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_rsp_fields", 32'({rsp_timeout, rsp_err, rsp_op, rsp_data}), 32'd0);
        check("rst_i2c_regs", 32'({i2c_newd, i2c_op, i2c_addr, i2c_din}), 32'd0);

        // Directed single transactions
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Full command FIFO while the controller is busy, then in-order drain
        do_reset();
        auto_ctl = 1'b1; max_delay = 2; i2c_busy = 1'b1;
        for (int k = 0; k < DEPTH + 3 && cmd_ready; k++)
            tick(1'b1, {1'b1, 7'(8'h10 + k), 8'(k)}, 1'b0);
        check("full_count", 32'(cmd_count), 32'(DEPTH));
        check("full_ready", 32'(cmd_ready), 32'd0);
        check("full_accepted", 32'(pushed_cnt), 32'(DEPTH + 1));
        tick(1'b1, {1'b0, 7'h7E, 8'hEE}, 1'b0);
        tick(1'b1, {1'b0, 7'h7E, 8'hEE}, 1'b0);
        check("full_refused", 32'(cmd_count), 32'(DEPTH));
        check("full_busy_no_newd", 32'(newd_cnt), 32'd0);
        drain(400);
        check("full_all_issued", 32'(newd_cnt), 32'(DEPTH + 1));

        // Response back-pressure stalls issue until a response is consumed
        do_reset();
        auto_ctl = 1'b1; max_delay = 3;
        for (int c = 0; c < 200; c++)
            tick(pushed_cnt < DEPTH + 2, {1'($urandom), 7'(c), 8'($urandom)}, 1'b0);
        check("bp_newd_stalled", 32'(newd_cnt), 32'(DEPTH));
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_cmd_left", 32'(cmd_count), 32'd2);
        tick(1'b0, 16'd0, 1'b1);
        for (int c = 0; c < 30; c++) tick(1'b0, 16'd0, 1'b0);
        check("bp_resume", 32'(newd_cnt), 32'(DEPTH + 1));
        drain(400);

        // Timeout, then a late done that must be ignored
        do_reset();
        auto_ctl = 1'b0;
        push_one({1'b0, 7'h33, 8'h99});
        wait_newd("tmo_newd_seen");
        n = 0;
        while (!rsp_valid && n < TIMEOUT + 10) begin
            step();
            n++;
        end
        check("tmo_latency", 32'(n), 32'(TIMEOUT + 1));
        check("tmo_rsp", 32'({rsp_timeout, rsp_err, rsp_op, rsp_data}), 32'({1'b1, 1'b1, 1'b0, 8'h00}));
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        repeat (9) step();
        i2c_done = 1'b1; i2c_ack_err = 1'b0; i2c_dout = 8'hAA;
        step();
        i2c_done = 1'b0;
        repeat (10) step();
        check("tmo_late_done_rsp", 32'(rsp_valid), 32'd0);
        check("tmo_late_done_idle", 32'(idle), 32'd1);
        check("tmo_newd_once", 32'(newd_cnt), 32'd1);

        // Reset while waiting on the controller
        do_reset();
        push_one({1'b0, 7'h44, 8'h11});
        wait_newd("rstw_newd_seen");
        repeat (3) step();
        rst = 1'b1; step(); rst = 1'b0;
        check("rstw_cmd_count", 32'(cmd_count), 32'd0);
        check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstw_idle", 32'(idle), 32'd1);
        check("rstw_i2c_addr", 32'(i2c_addr), 32'd0);
        i2c_busy = 1'b1;
        push_one({1'b1, 7'h66, 8'h00});
        n0 = newd_cnt;
        repeat (10) step();
        check("rstw_busy_hold", 32'(newd_cnt - n0), 32'd0);
        i2c_busy = 1'b0;
        wait_newd("rstw_newd_after_busy");
        check("rstw_issue", 32'({i2c_op, i2c_addr}), 32'({1'b1, 7'h66}));
        i2c_done = 1'b1; i2c_ack_err = 1'b0; i2c_dout = 8'hE7;
        step();
        i2c_done = 1'b0;
        wait_rsp("rstw_rsp_seen");
        check("rstw_rsp", 32'({rsp_timeout, rsp_err, rsp_op, rsp_data}), 32'({1'b0, 1'b0, 1'b1, 8'hE7}));
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

        // Randomized traffic against the reference model
        do_reset();
        auto_ctl = 1'b1; max_delay = 8;
        for (int c = 0; c < 1500; c++) begin
            i2c_busy = ($urandom_range(0, 3) == 0);
            tick(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 2) != 0);
        end
        drain(600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=time limit reached required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/i2c_cmd_queue.md
I2C_CMD_QUEUE -- requirements
Module: i2c_cmd_queue

Interface
REQ-001 Parameter: DEPTH, 4, entries in each of the command and response FIFOs (power of 2, 2..16).
REQ-002 Parameter: TIMEOUT, 4096, cycles allowed from i2c_newd to i2c_done before the transaction is abandoned.
REQ-003 Single clock clk; reset rst is synchronous and active-high.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO can accept
- cmd_op  in  1  1 = read, 0 = write
- cmd_addr  in  7  7-bit slave address
- cmd_data  in  8  write data (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  8  read data (8'h00 for writes)
- rsp_op  out  1  op of the completed command
- rsp_err  out  1  ack error or timeout
- rsp_timeout  out  1  transaction timed out
- i2c_newd  out  1  start pulse to the I2C controller
- i2c_op  out  1  op to the controller
- i2c_addr  out  7  address to the controller
- i2c_din  out  8  write data to the controller
- i2c_dout  in  8  read data from the controller
- i2c_busy  in  1  controller busy
- i2c_ack_err  in  1  controller ack error
- i2c_done  in  1  controller transaction complete
- cmd_count  out  5  command FIFO occupancy
- idle  out  1  both FIFOs empty and FSM in IDLE

Function
REQ-005 The command FIFO entry is {op, addr, data}: 16 bits. The response FIFO entry is {timeout, err, op, data}: 11 bits. Both FIFOs are DEPTH deep and use registered read/write pointers with wrap-around.
REQ-006 cmd_ready = (cmd_count != DEPTH). A push occurs when cmd_valid && cmd_ready. A pushed entry is visible to the FSM no earlier than the next cycle.
REQ-007 rsp_valid = (response FIFO not empty). rsp_* present the head entry. A pop occurs when rsp_valid && rsp_ready.
REQ-008 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-009 IDLE -> ISSUE when the command FIFO is non-empty and the response FIFO is not full. On that transition:
- the head entry is popped into registers i2c_op, i2c_addr, i2c_din;
- i2c_op/i2c_addr/i2c_din are held stable until the FSM next leaves RESP.
REQ-010 ISSUE: remain while i2c_busy=1. When i2c_busy=0:
- assert i2c_newd for exactly one cycle;
- clear the timeout counter;
- go to WAIT.
REQ-011 WAIT: the counter increments each cycle.
- i2c_done=1 -> capture err=i2c_ack_err, timeout=0, data=(op ? i2c_dout : 8'h00); go to RESP.
- Else, counter reaching TIMEOUT-1 -> capture err=1, timeout=1, data=8'h00; go to RESP.
- If i2c_done and the timeout coincide, i2c_done wins.
REQ-012 RESP: push the captured entry into the response FIFO (one cycle), then go to IDLE. Space is guaranteed by REQ-009.
REQ-013 i2c_done and i2c_ack_err are ignored outside WAIT; a late done after a timeout is discarded.
REQ-014 At most one transaction is in flight. Back-to-back commands are separated by at least one IDLE cycle.
REQ-015 Simultaneous push and pop on either FIFO in the same cycle leaves occupancy unchanged and preserves order.
REQ-016 idle = (FSM==IDLE) && cmd FIFO empty && response FIFO empty.

Reset
REQ-017 While rst=1 at a clk edge, the following are cleared:
- both FIFOs flushed (pointers and counts 0);
- FSM = IDLE; timeout counter = 0;
- i2c_newd=0, i2c_op=0, i2c_addr=0, i2c_din=0.
REQ-018 After reset: cmd_ready=1, rsp_valid=0, cmd_count=0, idle=1; rsp_data/rsp_op/rsp_err/rsp_timeout read 0.
REQ-019 Reset mid-transaction drops the in-flight command and sends no abort to the controller. The next ISSUE waits on i2c_busy=0 per REQ-010.

Verification
REQ-020 Write: push {op=0, addr=7'h50, data=8'hA5}, controller done after 20 cycles with ack_err=0 -> exactly one i2c_newd pulse with addr=50/din=A5; response {timeout=0, err=0, op=0, data=00}.
REQ-021 Read: push {op=1, addr=7'h21}, done with i2c_dout=8'h3C -> response data=3C, err=0. If ack_err=1 at done -> err=1, timeout=0.
REQ-022 Full/order: push DEPTH+1 commands with i2c_busy held 1 -> cmd_ready=0 once cmd_count=DEPTH, the extra push is refused. Release busy -> responses return in push order.
REQ-023 Back-pressure: rsp_ready=0 until the response FIFO is full -> no further i2c_newd is issued. Pop one response -> the next issue resumes.
REQ-024 Timeout: never assert i2c_done -> after TIMEOUT cycles the response is {timeout=1, err=1, data=00}. A done arriving 10 cycles later produces no extra response.
REQ-025 Reset in WAIT, then push a new command while i2c_busy=1 -> no newd until busy=0; FIFOs report empty immediately after reset.
